multicycle_controller: RTL and testbench

Parametrised successor to the CPU's multi-cycle control FSM. Sequences fetch, decode and execute for the 16-bit ISA and drives the datapath control strobes. Adds three things: a variable-latency memory handshake (mem_req/mem_ready) with a timeout fault, interrupt entry with wake-from-halt, and an illegal-opcode fault. Also exposes a retired-instruction counter. Sits between the instruction/data memory interface and the datapath (register file, ALU, PC).

---
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit ISA: fetch/decode/execute sequencing with
// a variable-latency memory handshake, timeout and illegal-opcode faults, and interrupt entry.
module multicycle_controller #(
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   Z,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   mem_ready,
  input  logic                   irq,
  input  logic                   irq_enable,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   fetch_instruction,
  output logic                   alu_override_imm8,
  output logic                   alu_override_imm4,
  output logic                   alu_set_flags,
  output logic                   set_pc,
  output logic                   pc_from_register,
  output logic                   mem_write,
  output logic                   mem_req,
  output logic                   pc_from_vector,
  output logic                   save_pc,
  output logic                   irq_ack,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_W-1:0]       retired_count,
  output logic [11:0]            state
);

  // One-hot encoding, so the state register doubles as the debug state output.
  typedef enum logic [11:0] {
    S_IDLE        = 12'b1000_0000_0000,
    S_FETCH_REQ   = 12'b0100_0000_0000,
    S_FETCH_LATCH = 12'b0010_0000_0000,
    S_DECODE      = 12'b0001_0000_0000,
    S_LOAD_REQ    = 12'b0000_1000_0000,
    S_LOAD_WB     = 12'b0000_0100_0000,
    S_STORE_REQ   = 12'b0000_0010_0000,
    S_JMP         = 12'b0000_0001_0000,
    S_ALU         = 12'b0000_0000_1000,
    S_IRQ_ENTRY   = 12'b0000_0000_0100,
    S_HALT        = 12'b0000_0000_0010,
    S_FAULT       = 12'b0000_0000_0001
  } state_e;

  localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TO_LAST_I);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic                 retire;
  logic                 in_req;
  logic                 timeout_hit;
  logic [3:0]           opcode;
  logic                 unused_instr;

  assign opcode       = instruction[INSTR_WIDTH-1 -: 4];
  assign unused_instr = ^instruction;

  // Memory handshake: mem_req is held high for every cycle of a request state; the
  // request completes on the first cycle mem_ready is sampled high, and mem_ready
  // is ignored whenever mem_req is low.
  assign in_req      = (state_q == S_FETCH_REQ) || (state_q == S_LOAD_REQ) ||
                       (state_q == S_STORE_REQ);
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_req && !mem_ready && (wait_q == TO_LAST);

  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    reg_write         = 1'b0;
    mem_to_reg        = 1'b0;
    fetch_instruction = 1'b0;
    alu_override_imm8 = 1'b0;
    alu_override_imm4 = 1'b0;
    alu_set_flags     = 1'b0;
    set_pc            = 1'b0;
    pc_from_register  = 1'b0;
    mem_write         = 1'b0;
    mem_req           = 1'b0;
    pc_from_vector    = 1'b0;
    save_pc           = 1'b0;
    irq_ack           = 1'b0;
    halted            = 1'b0;
    fault             = 1'b0;
    case (state_q)
      S_IDLE: state_d = (irq && irq_enable) ? S_IRQ_ENTRY : S_FETCH_REQ;
      S_FETCH_REQ: begin
        mem_req           = 1'b1;
        fetch_instruction = 1'b1;
        if (mem_ready) state_d = S_FETCH_LATCH;
      end
      S_FETCH_LATCH: begin
        fetch_instruction = 1'b1;
        state_d           = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          4'b0000:                   state_d = S_LOAD_REQ;
          4'b0001:                   state_d = S_STORE_REQ;
          4'b0010, 4'b1000, 4'b1001: state_d = S_ALU;
          4'b0100:                   state_d = S_JMP;
          4'b0111:                   state_d = S_HALT;
          default:                   state_d = S_FAULT;
        endcase
      end
      S_LOAD_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        set_pc     = 1'b1;
        retire     = 1'b1;
        state_d    = S_IDLE;
      end
      S_STORE_REQ: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        set_pc    = mem_ready;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_JMP: begin
        set_pc           = 1'b1;
        pc_from_register = Z ^ instruction[7];
        retire           = 1'b1;
        state_d          = S_IDLE;
      end
      S_ALU: begin
        reg_write         = 1'b1;
        alu_set_flags     = 1'b1;
        set_pc            = 1'b1;
        alu_override_imm8 = (opcode == 4'b0010);
        alu_override_imm4 = (opcode == 4'b1001);
        retire            = 1'b1;
        state_d           = S_IDLE;
      end
      S_IRQ_ENTRY: begin
        save_pc        = 1'b1;
        set_pc         = 1'b1;
        pc_from_vector = 1'b1;
        irq_ack        = 1'b1;
        state_d        = S_FETCH_REQ;
      end
      S_HALT: begin
        halted = 1'b1;
        if (irq && irq_enable) state_d = S_IRQ_ENTRY;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    // A ready arriving on the last tolerated cycle never reaches here: timeout_hit needs !mem_ready.
    if (timeout_hit) state_d = S_FAULT;
  end

  // Staying in the same request state without ready is the only way the counter advances.
  assign wait_d    = (in_req && !mem_ready && (state_d == state_q)) ? wait_q + TIMEOUT_W'(1) : '0;
  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state         = state_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a reactive memory responder, an instruction-level
// reference model feeding an expected queue, and a monitor comparing per-instruction records.
module tb_multicycle_controller;
  localparam int IW = 16;
  localparam int TW = 8;
  localparam int MT = 4;
  localparam int CW = 32;
  localparam int W  = 96;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          Z = 1'b0;
  logic [IW-1:0] instruction = '0;
  logic          mem_ready;
  logic          irq = 1'b0;
  logic          irq_enable = 1'b0;
  logic reg_write, mem_to_reg, fetch_instruction, alu_override_imm8, alu_override_imm4;
  logic alu_set_flags, set_pc, pc_from_register, mem_write, mem_req, pc_from_vector;
  logic save_pc, irq_ack, halted, fault;
  logic [CW-1:0] retired_count;
  logic [11:0]   state;

  multicycle_controller #(
    .INSTR_WIDTH(IW), .TIMEOUT_W(TW), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .Z(Z), .instruction(instruction),
    .mem_ready(mem_ready), .irq(irq), .irq_enable(irq_enable),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fetch_instruction(fetch_instruction),
    .alu_override_imm8(alu_override_imm8), .alu_override_imm4(alu_override_imm4),
    .alu_set_flags(alu_set_flags), .set_pc(set_pc), .pc_from_register(pc_from_register),
    .mem_write(mem_write), .mem_req(mem_req), .pc_from_vector(pc_from_vector),
    .save_pc(save_pc), .irq_ack(irq_ack), .halted(halted), .fault(fault),
    .retired_count(retired_count), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int f_cur = 0;
  int d_cur = 0;
  int recs = 0;
  int model_retired = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int kind, input int cyc, input int mreq,
      input int fch, input int regw, input int m2r, input int setpc, input int pfr,
      input int imm8, input int imm4, input int mw, input int flg, input int misc,
      input int ret);
    return W'({kind[1:0], cyc[7:0], mreq[7:0], fch[7:0], regw[3:0], m2r[3:0], setpc[3:0],
               pfr[3:0], imm8[3:0], imm4[3:0], mw[7:0], flg[3:0], misc[3:0], ret[15:0]});
  endfunction

  // Instruction-level model: kind 0 = back to IDLE, 1 = HALT, 2 = FAULT. Cycle counts run
  // from the IDLE cycle up to (not including) the next IDLE/HALT/FAULT cycle.
  task automatic model(input logic [15:0] ins, input logic z, input int f, input int d,
                       output int kind, output logic [W-1:0] e);
    int cyc, mreq, fch, regw, m2r, setpc, pfr, imm8, imm4, mw, flg;
    logic [3:0] op;
    op = ins[15:12];
    cyc = 1; mreq = 0; fch = 0; regw = 0; m2r = 0; setpc = 0; pfr = 0;
    imm8 = 0; imm4 = 0; mw = 0; flg = 0; kind = 0;
    if (f >= MT) begin
      cyc += MT; mreq = MT; fch = MT; kind = 2;
    end else begin
      cyc += f + 3; mreq = f + 1; fch = f + 2;
      case (op)
        4'h0: if (d >= MT) begin cyc += MT; mreq += MT; kind = 2; end
              else begin cyc += d + 2; mreq += d + 1; regw = 1; m2r = 1; setpc = 1; model_retired++; end
        4'h1: if (d >= MT) begin cyc += MT; mreq += MT; mw = MT; kind = 2; end
              else begin cyc += d + 1; mreq += d + 1; mw = d + 1; setpc = 1; model_retired++; end
        4'h2, 4'h8, 4'h9: begin
          cyc += 1; regw = 1; flg = 1; setpc = 1;
          imm8 = (op == 4'h2) ? 1 : 0; imm4 = (op == 4'h9) ? 1 : 0; model_retired++;
        end
        4'h4: begin cyc += 1; setpc = 1; pfr = (z ^ ins[7]) ? 1 : 0; model_retired++; end
        4'h7: kind = 1;
        default: kind = 2;
      endcase
    end
    e = pack(kind, cyc, mreq, fch, regw, m2r, setpc, pfr, imm8, imm4, mw, flg, 0, model_retired);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int age;
    age = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_req) begin
        mem_ready = (age >= (fetch_instruction ? f_cur : d_cur));
        age++;
      end else begin
        age = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit open = 0;
  int a_cyc, a_mreq, a_fch, a_regw, a_m2r, a_setpc, a_pfr, a_imm8, a_imm4, a_mw, a_flg, a_misc;

  always @(negedge clock) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int kind;
    if (reset) begin
      open = 0;
    end else begin
      if (open && (state[11] || state[1] || state[0])) begin
        kind = state[11] ? 0 : (state[1] ? 1 : 2);
        obs = pack(kind, a_cyc, a_mreq, a_fch, a_regw, a_m2r, a_setpc, a_pfr, a_imm8, a_imm4,
                   a_mw, a_flg, a_misc, int'(retired_count[15:0]));
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL record: got %0h expected nothing pending", obs);
        end else begin
          e = exp_q.pop_front();
          chk("record", obs, e);
        end
        recs++;
        open = 0;
      end
      if (state[11]) begin
        open = 1;
        a_cyc = 0; a_mreq = 0; a_fch = 0; a_regw = 0; a_m2r = 0; a_setpc = 0; a_pfr = 0;
        a_imm8 = 0; a_imm4 = 0; a_mw = 0; a_flg = 0; a_misc = 0;
      end
      if (open) begin
        a_cyc++;
        a_mreq  += int'(mem_req);
        a_fch   += int'(fetch_instruction);
        a_regw  += int'(reg_write);
        a_m2r   += int'(mem_to_reg);
        a_setpc += int'(set_pc);
        a_pfr   += int'(pc_from_register);
        a_imm8  += int'(alu_override_imm8);
        a_imm4  += int'(alu_override_imm4);
        a_mw    += int'(mem_write);
        a_flg   += int'(alu_set_flags);
        a_misc  += int'(save_pc | pc_from_vector | irq_ack | halted | fault);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    irq = 1'b0;
    irq_enable = 1'b0;
    #1 chk("reset_state",
           {state, reg_write, mem_to_reg, fetch_instruction, alu_override_imm8,
            alu_override_imm4, alu_set_flags, set_pc, pc_from_register, mem_write, mem_req,
            pc_from_vector, save_pc, irq_ack, halted, fault, retired_count},
           {12'h800, 15'b0, 32'b0});
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_retired = 0;
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!state[11] && n < 300) begin
      @(negedge clock); #1;
      n++;
    end
    if (!state[11]) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: got state %0h expected 800 within 300 cycles", state);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic z, input int f, input int d,
                       output int kind);
    logic [W-1:0] e;
    int r0, n;
    wait_idle();
    instruction = ins;
    Z = z;
    f_cur = f;
    d_cur = d;
    model(ins, z, f, d, kind, e);
    exp_q.push_back(e);
    r0 = recs;
    n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while (recs == r0 && n < 300);
    if (recs == r0) begin
      vectors++; miscompares++;
      $display("FAIL completion: got no record for %0h expected one within 300 cycles", ins);
    end
  endtask

  task automatic run(input logic [15:0] ins, input logic z, input int f, input int d);
    int kind;
    issue(ins, z, f, d, kind);
    if (kind != 0) do_reset();
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] legal_ops[6] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h9, 4'h4};
  logic [3:0] bad_ops[9]   = '{4'h3, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  initial begin
    int kind, n, r;
    logic [3:0] op;
    do_reset();

    run(16'h9123, 1'b0, 0, 0);
    run(16'h0abc, 1'b0, 0, 3);
    run(16'h4080, 1'b0, 0, 0);
    run(16'h4000, 1'b0, 0, 0);
    run(16'h4080, 1'b1, 1, 0);
    run(16'h2011, 1'b0, 2, 0);
    run(16'h8000, 1'b1, 0, 0);
    run(16'h1234, 1'b0, 0, 2);
    run(16'h0000, 1'b0, MT - 1, MT - 1);
    run(16'h1fff, 1'b0, MT - 1, MT - 1);

    issue(16'h2000, 1'b0, MT, 0, kind);
    repeat (3) @(negedge clock);
    #1 chk("fetch_timeout_sticky", {fault, state}, {1'b1, 12'h001});
    do_reset();

    run(16'h0123, 1'b0, 1, MT);
    run(16'h1123, 1'b0, 0, MT);
    run(16'hF000, 1'b0, 0, 0);

    // Halt, ignore irq without enable, then take the interrupt.
    run(16'h9001, 1'b0, 0, 0);
    issue(16'h7000, 1'b0, 0, 0, kind);
    irq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      chk("halt_hold", {halted, state}, {1'b1, 12'h002});
    end
    instruction = 16'h2005;
    f_cur = 0;
    irq_enable = 1'b1;
    @(negedge clock); #1;
    chk("irq_entry", {state, irq_ack, save_pc, pc_from_vector, set_pc, halted},
        {12'h004, 5'b11110});
    irq = 1'b0;
    irq_enable = 1'b0;
    model_retired++;
    @(negedge clock); #1;
    chk("irq_fetch", {state, irq_ack, mem_req}, {12'h400, 1'b0, 1'b1});

    run(16'h8123, 1'b0, 0, 0);

    // Asynchronous reset in the middle of a store stall.
    wait_idle();
    instruction = 16'h1000;
    f_cur = 0;
    d_cur = 3;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_write && n < 50);
    #2 reset = 1'b1;
    #1 chk("reset_mid_store", {mem_req, mem_write, retired_count, state},
           {1'b0, 1'b0, 32'b0, 12'h800});
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_retired = 0;

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 82)      op = legal_ops[$urandom_range(0, 5)];
      else if (r < 90) op = 4'h7;
      else             op = bad_ops[$urandom_range(0, 8)];
      irq = 1'($urandom_range(0, 1));
      run({op, 12'($urandom)}, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 11) == 0) ? MT : $urandom_range(0, MT - 1),
          ($urandom_range(0, 11) == 0) ? MT : $urandom_range(0, MT - 1));
    end

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL leftover: got %0d pending records expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
